// File: rtl/rot_sw_7seg_pkg.sv
// Shared constants for the rotary-switch 7-segment display: segment patterns,
// drive polarity and the debounce counter sizing helper.
package rot_sw_7seg_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  localparam logic [6:0] SEG_BLANK = {7{SEG_OFF}};

  // Bit order {A,B,C,D,E,F,G}, active-low
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/rot_sw_7seg_if.sv
// Code-to-segment bus between a hex source and a 7-segment decoder.
interface rot_sw_7seg_if;
  logic [3:0] code;
  logic [6:0] seg;

  modport master (output code, input  seg);
  modport slave  (input  code, output seg);
endinterface

// File: rtl/rot_sw_7seg_dec.sv
// hex_to_7seg: purely combinational 4-bit to active-low 7-segment decoder.
module hex_to_7seg
  import rot_sw_7seg_pkg::*;
(
  rot_sw_7seg_if.slave bus
);

  assign bus.seg = SEG_PAT[bus.code];

endmodule

// File: rtl/rot_sw_7seg.sv
// Rotary hex switch to 7-segment display: 2-flop synchronizer, stability
// debounce, display-valid flag and flop-driven segment/decimal-point outputs.
module rot_sw_7seg
  import rot_sw_7seg_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic R3,
  input  logic R2,
  input  logic R1,
  input  logic R0,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G,
  output logic Dp
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       sync_p0, sync_p1, prev_p2;
  logic [CNT_W-1:0] cnt_p2, cnt_nxt;
  logic [3:0]       disp_code;
  logic             disp_vld;
  logic             diff, accept;
  logic [6:0]       seg_p3;
  logic             dp_p3;

  rot_sw_7seg_if dec_bus ();

  assign dec_bus.code = disp_code;

  hex_to_7seg u_dec (.bus(dec_bus));

  // cnt_p2 holds (cycles the code has been stable) - 1, saturating at DB_CYCLES
  // so acceptance fires exactly once per stable run.
  always_comb begin
    diff    = (sync_p1 != prev_p2);
    cnt_nxt = cnt_p2;
    if (diff)
      cnt_nxt = '0;
    else if (cnt_p2 != CNT_SAT)
      cnt_nxt = cnt_p2 + CNT_W'(1);
    // A code already settled at reset release is still taken once
    accept = (cnt_nxt == CNT_ACC) || (!disp_vld && (cnt_nxt == CNT_SAT));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      prev_p2   <= '0;
      cnt_p2    <= '0;
      disp_code <= '0;
      disp_vld  <= 1'b0;
      seg_p3    <= SEG_BLANK;
      dp_p3     <= SEG_OFF;
    end else begin
      // stage 0/1: synchronizer
      sync_p0 <= {R3, R2, R1, R0};
      sync_p1 <= sync_p0;
      // stage 2: stability tracking and acceptance
      prev_p2 <= sync_p1;
      cnt_p2  <= cnt_nxt;
      if (accept) begin
        disp_code <= sync_p1;
        disp_vld  <= 1'b1;
      end
      // stage 3: output registers
      seg_p3 <= disp_vld ? dec_bus.seg : SEG_BLANK;
      dp_p3  <= (disp_vld && (sync_p1 != disp_code)) ? SEG_ON : SEG_OFF;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_p3;
  assign Dp = dp_p3;

endmodule

// File: tb/tb_rot_sw_7seg.sv
// Bench for rot_sw_7seg: directed scenarios plus random switch activity,
// checked every cycle against a run-length model for DB_CYCLES = 4 and 1.
module tb_rot_sw_7seg;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;

  rot_sw_7seg_if io ();

  logic [6:0] seg4, seg1;
  logic       dp4, dp1;

  rot_sw_7seg dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .R3(io.code[3]), .R2(io.code[2]), .R1(io.code[1]), .R0(io.code[0]),
    .A(seg4[6]), .B(seg4[5]), .C(seg4[4]), .D(seg4[3]),
    .E(seg4[2]), .F(seg4[1]), .G(seg4[0]), .Dp(dp4)
  );

  rot_sw_7seg #(.DB_CYCLES(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .R3(io.code[3]), .R2(io.code[2]), .R1(io.code[1]), .R0(io.code[0]),
    .A(seg1[6]), .B(seg1[5]), .C(seg1[4]), .D(seg1[3]),
    .E(seg1[2]), .F(seg1[1]), .G(seg1[0]), .Dp(dp1)
  );

  assign io.seg = seg4;

  always #5 CLK = ~CLK;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam int DBV [2] = '{4, 1};

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  // Reference model: history of synchronized codes, one entry per cycle
  int         sync_q[$];
  int         last_r;
  bit         m_valid [2];
  int         m_code  [2];
  logic [7:0] exp_o   [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    sync_q.delete();
    sync_q.push_back(0);
    sync_q.push_back(0);
    last_r = 0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_code[i]  = 0;
      exp_o[i]   = 8'hFF;
    end
  endtask

  task automatic model_edge();
    int cur;
    int run;
    cur = sync_q[sync_q.size()-1];
    run = 0;
    for (int k = sync_q.size() - 1; k >= 0; k--) begin
      if (sync_q[k] != cur) break;
      run++;
    end
    for (int i = 0; i < 2; i++) begin
      exp_o[i] = {m_valid[i] ? PAT[m_code[i]] : 7'h7F,
                  (m_valid[i] && cur != m_code[i]) ? 1'b0 : 1'b1};
      if (run == DBV[i] || (!m_valid[i] && run > DBV[i])) begin
        m_valid[i] = 1'b1;
        m_code[i]  = cur;
      end
    end
    sync_q.push_back(last_r);
    if (sync_q.size() > 16) void'(sync_q.pop_front());
    last_r = int'(io.code);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_edge();
    #1;
    chk({phase, "_db4"}, {seg4, dp4}, exp_o[0]);
    chk({phase, "_db1"}, {seg1, dp1}, exp_o[1]);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    io.code = v;
    repeat (n) tick();
  endtask

  initial begin
    bit dp_seen;
    io.code = 4'd5;
    #1 RST_N = 1'b0;
    #2;
    model_reset();
    chk("rst_async_db4", {seg4, dp4}, 8'hFF);
    chk("rst_async_db1", {seg1, dp1}, 8'hFF);
    repeat (3) tick();

    // Reset release with R = 5 held
    #1 RST_N = 1'b1;
    phase = "rst_rel";
    repeat (6) tick();
    chk("rst_blank6", {seg4, dp4}, 8'hFF);
    tick();
    chk("rst_lat7", {seg4, dp4}, {7'b0100100, 1'b1});

    phase = "sweep";
    for (int v = 0; v < 16; v++) begin
      hold(4'(v), 20);
      chk($sformatf("sweep_%0d", v), {1'b0, seg4}, {1'b0, PAT[v]});
    end

    phase = "bounce";
    hold(4'd3, 20);
    chk("bounce_pre", {seg4, dp4}, {7'b0000110, 1'b1});
    dp_seen = 1'b0;
    io.code = 4'd4;
    repeat (2) begin tick(); if (!dp4) dp_seen = 1'b1; end
    io.code = 4'd3;
    repeat (10) begin tick(); if (!dp4) dp_seen = 1'b1; end
    chk("bounce_seg", {seg4, dp4}, {7'b0000110, 1'b1});
    chk("bounce_dp_pulse", {7'b0, dp_seen}, 8'd1);

    phase = "latency";
    hold(4'd8, 20);
    io.code = 4'd9;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("lat_seg_%0d", k), {1'b0, seg4},
          {1'b0, (k == 7) ? 7'b0000100 : 7'b0000000});
      chk($sformatf("lat_dp_%0d", k), {7'b0, dp4},
          {7'b0, (k >= 3 && k <= 6) ? 1'b0 : 1'b1});
    end

    phase = "midrst";
    hold(4'd1, 20);
    io.code = 4'd2;
    repeat (3) tick();
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_async_db4", {seg4, dp4}, 8'hFF);
    chk("midrst_async_db1", {seg1, dp1}, 8'hFF);
    model_reset();
    repeat (2) tick();
    #1 RST_N = 1'b1;
    repeat (6) tick();
    chk("midrst_blank6", {seg4, dp4}, 8'hFF);
    tick();
    chk("midrst_lat7", {seg4, dp4}, {7'b0010010, 1'b1});

    phase = "db1";
    hold(4'hA, 20);
    io.code = 4'hB;
    repeat (3) tick();
    chk("db1_hold3", {1'b0, seg1}, {1'b0, 7'b0001000});
    tick();
    chk("db1_lat4", {1'b0, seg1}, {1'b0, 7'b1100000});

    phase = "random";
    repeat (60) begin
      io.code = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 8)) tick();
    end
    hold(4'($urandom_range(0, 15)), 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
